// File: rtl/rdma_rc_psn_checker_if.sv
// rdma_rc_psn_checker_if: ACK/NAK valid/ready channel toward the TX responder.
// valid, is_nak, psn, syndrome flow master -> slave; ready flows slave -> master.
interface rdma_rc_psn_checker_if #(
  parameter int PSN_WIDTH = 24
);
  logic                 valid;
  logic                 ready;
  logic                 is_nak;
  logic [PSN_WIDTH-1:0] psn;
  logic [7:0]           syndrome;
  modport master (output valid, is_nak, psn, syndrome, input ready);
  modport slave  (input valid, is_nak, psn, syndrome, output ready);
endinterface

// File: rtl/rdma_rc_psn_checker.sv
// rdma_rc_psn_checker: RC receive PSN sequencing with coalesced ACK and sequence-NAK generation.
// Ports: clk, rst_n (async active-low); parser results parse_done, pdu_opcode, pdu_psn,
// is_data_frame, opcode_err, qpn_mismatch_err; qp_state; epsn_load/init_epsn (ePSN init);
// ack (master side of the ACK/NAK channel); pulses data_accept, dup_drop, seq_err;
// epsn and nak_outstanding status. Defining RDMA_PSN_STATS_EN adds saturating
// stat_dup_cnt, stat_seq_cnt and stat_ack_cnt counters.
module rdma_rc_psn_checker #(
  parameter int                   PSN_WIDTH    = 24,
  parameter int                   OPCODE_WIDTH = 8,
  parameter int                   ACK_COALESCE = 4,
  parameter logic [7:0]           SYN_ACK      = 8'h00,
  parameter logic [7:0]           SYN_NAK_SEQ  = 8'h60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    parse_done,
  input  logic [OPCODE_WIDTH-1:0] pdu_opcode,
  input  logic [PSN_WIDTH-1:0]    pdu_psn,
  input  logic                    is_data_frame,
  input  logic                    opcode_err,
  input  logic                    qpn_mismatch_err,
  input  logic [2:0]              qp_state,
  input  logic                    epsn_load,
  input  logic [PSN_WIDTH-1:0]    init_epsn,
  rdma_rc_psn_checker_if.master   ack,
  output logic                    data_accept,
  output logic                    dup_drop,
  output logic                    seq_err,
  output logic [PSN_WIDTH-1:0]    epsn,
  output logic                    nak_outstanding
`ifdef RDMA_PSN_STATS_EN
  ,
  output logic [31:0]             stat_dup_cnt,
  output logic [31:0]             stat_seq_cnt,
  output logic [31:0]             stat_ack_cnt
`endif
);
  localparam logic [2:0] RTS = 3'b011;
  typedef enum logic {NORMAL = 1'b0, NAK_WAIT = 1'b1} state_t;
  state_t               state, state_nxt;
  logic [7:0]           cnt;
  logic [PSN_WIDTH-1:0] d;
  logic                 qual, in_order, dup, ooo, cnt_hit, fire, gen_ack, gen_nak, ack_blocked;
  logic                 unused_opcode;
  assign unused_opcode = ^pdu_opcode;
  // epsn_load masks the frame so a load cycle never classifies anything.
  always_comb begin
    qual        = parse_done & is_data_frame & ~opcode_err & ~qpn_mismatch_err & (qp_state == RTS) & ~epsn_load;
    d           = pdu_psn - epsn;
    in_order    = qual & (d == '0);
    dup         = qual & d[PSN_WIDTH-1];
    ooo         = qual & ~in_order & ~dup;
    cnt_hit     = (cnt + 8'd1) == 8'(ACK_COALESCE);
    fire        = ack.valid & ack.ready;
    gen_ack     = (in_order & cnt_hit) | dup;
    gen_nak     = ooo & ~nak_outstanding;
    // A pending NAK that is not leaving this cycle must not be overwritten by an ACK.
    ack_blocked = ack.valid & ack.is_nak & ~fire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= NORMAL;
    else        state <= state_nxt;
  always_comb
    state_nxt = (epsn_load | in_order | (qp_state != RTS)) ? NORMAL : ooo ? NAK_WAIT : state;
  always_comb
    nak_outstanding = state == NAK_WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      epsn         <= '0;
      cnt          <= '0;
      data_accept  <= 1'b0;
      dup_drop     <= 1'b0;
      seq_err      <= 1'b0;
      ack.valid    <= 1'b0;
      ack.is_nak   <= 1'b0;
      ack.psn      <= '0;
      ack.syndrome <= '0;
    end else begin
      data_accept <= in_order;
      dup_drop    <= dup;
      seq_err     <= ooo;
      epsn        <= epsn_load ? init_epsn : in_order ? epsn + 1'b1 : epsn;
      cnt         <= epsn_load ? '0 : in_order ? (cnt_hit ? '0 : cnt + 8'd1) : cnt;
      if (epsn_load) ack.valid <= 1'b0;
      else if (gen_nak) begin
        ack.valid    <= 1'b1;
        ack.is_nak   <= 1'b1;
        ack.psn      <= epsn;
        ack.syndrome <= SYN_NAK_SEQ;
      end else if (gen_ack & ~ack_blocked) begin
        ack.valid    <= 1'b1;
        ack.is_nak   <= 1'b0;
        ack.psn      <= in_order ? pdu_psn : epsn - 1'b1;
        ack.syndrome <= SYN_ACK;
      end else if (fire) ack.valid <= 1'b0;
    end
`ifdef RDMA_PSN_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_dup_cnt <= '0;
      stat_seq_cnt <= '0;
      stat_ack_cnt <= '0;
    end else begin
      stat_dup_cnt <= epsn_load ? '0 : (dup_drop & ~&stat_dup_cnt) ? stat_dup_cnt + 32'd1 : stat_dup_cnt;
      stat_seq_cnt <= epsn_load ? '0 : (seq_err & ~&stat_seq_cnt) ? stat_seq_cnt + 32'd1 : stat_seq_cnt;
      stat_ack_cnt <= epsn_load ? '0 : (fire & ~&stat_ack_cnt) ? stat_ack_cnt + 32'd1 : stat_ack_cnt;
    end
`endif
endmodule

// File: tb/tb_rdma_rc_psn_checker.sv
// tb_rdma_rc_psn_checker: directed table-driven bench for rdma_rc_psn_checker.
module tb_rdma_rc_psn_checker;
  localparam logic [2:0] R   = 3'b011;
  localparam logic [2:0] RTR = 3'b010;
  typedef struct {
    logic        ld;
    logic [23:0] ip;
    logic [2:0]  qs;
    logic        pd, df, oe, qe;
    logic [23:0] psn;
    logic        rdy;
    logic        da, dd, se;
    logic [23:0] ep;
    logic        no, av, an;
    logic [23:0] ap;
    logic [7:0]  as;
  } vec_t;
  logic        clk, rst_n, parse_done, is_data_frame, opcode_err, qpn_mismatch_err, epsn_load;
  logic [7:0]  pdu_opcode;
  logic [23:0] pdu_psn, init_epsn, epsn;
  logic [2:0]  qp_state;
  logic        data_accept, dup_drop, seq_err, nak_outstanding;
`ifdef RDMA_PSN_STATS_EN
  logic [31:0] stat_dup_cnt, stat_seq_cnt, stat_ack_cnt;
`endif
  int          total, passed;
  vec_t        tv[37];
  rdma_rc_psn_checker_if #(.PSN_WIDTH(24)) ack_if();
  rdma_rc_psn_checker dut (
    .clk(clk), .rst_n(rst_n), .parse_done(parse_done), .pdu_opcode(pdu_opcode), .pdu_psn(pdu_psn),
    .is_data_frame(is_data_frame), .opcode_err(opcode_err), .qpn_mismatch_err(qpn_mismatch_err),
    .qp_state(qp_state), .epsn_load(epsn_load), .init_epsn(init_epsn), .ack(ack_if),
    .data_accept(data_accept), .dup_drop(dup_drop), .seq_err(seq_err), .epsn(epsn),
    .nak_outstanding(nak_outstanding)
`ifdef RDMA_PSN_STATS_EN
    , .stat_dup_cnt(stat_dup_cnt), .stat_seq_cnt(stat_seq_cnt), .stat_ack_cnt(stat_ack_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  function automatic vec_t mk(logic ld, logic [23:0] ip, logic [2:0] qs, logic pd, logic df, logic oe, logic qe,
                              logic [23:0] psn, logic rdy, logic da, logic dd, logic se, logic [23:0] ep,
                              logic no, logic av, logic an, logic [23:0] ap, logic [7:0] as);
    vec_t v;
    v.ld = ld; v.ip = ip; v.qs = qs; v.pd = pd; v.df = df; v.oe = oe; v.qe = qe; v.psn = psn; v.rdy = rdy;
    v.da = da; v.dd = dd; v.se = se; v.ep = ep; v.no = no; v.av = av; v.an = an; v.ap = ap; v.as = as;
    return v;
  endfunction
  function automatic vec_t fr(logic [23:0] psn, logic rdy, logic da, logic dd, logic se, logic [23:0] ep,
                              logic no, logic av, logic an, logic [23:0] ap, logic [7:0] as);
    return mk(1'b0, 24'h0, R, 1'b1, 1'b1, 1'b0, 1'b0, psn, rdy, da, dd, se, ep, no, av, an, ap, as);
  endfunction
  task automatic drive(input vec_t v);
    epsn_load = v.ld; init_epsn = v.ip; qp_state = v.qs; parse_done = v.pd; is_data_frame = v.df;
    opcode_err = v.oe; qpn_mismatch_err = v.qe; pdu_psn = v.psn; ack_if.ready = v.rdy;
  endtask
  initial begin
    total = 0; passed = 0;
    pdu_opcode = 8'h04;
    tv[0]  = mk(1, 24'h10, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h10, 0, 0, 0, 0, 0);
    tv[1]  = fr(24'h10, 1,  1, 0, 0, 24'h11, 0, 0, 0, 0, 0);
    tv[2]  = fr(24'h11, 1,  1, 0, 0, 24'h12, 0, 0, 0, 0, 0);
    tv[3]  = fr(24'h12, 1,  1, 0, 0, 24'h13, 0, 0, 0, 0, 0);
    tv[4]  = fr(24'h13, 1,  1, 0, 0, 24'h14, 0, 1, 0, 24'h13, 8'h00);
    tv[5]  = mk(0, 0, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h14, 0, 0, 0, 0, 0);
    tv[6]  = mk(1, 24'hFFFFFE, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'hFFFFFE, 0, 0, 0, 0, 0);
    tv[7]  = fr(24'hFFFFFE, 1,  1, 0, 0, 24'hFFFFFF, 0, 0, 0, 0, 0);
    tv[8]  = fr(24'hFFFFFF, 1,  1, 0, 0, 24'h000000, 0, 0, 0, 0, 0);
    tv[9]  = fr(24'h000000, 1,  1, 0, 0, 24'h000001, 0, 0, 0, 0, 0);
    tv[10] = mk(1, 24'h20, R, 0, 0, 0, 0, 0, 0,  0, 0, 0, 24'h20, 0, 0, 0, 0, 0);
    tv[11] = fr(24'h22, 0,  0, 0, 1, 24'h20, 1, 1, 1, 24'h20, 8'h60);
    tv[12] = fr(24'h23, 0,  0, 0, 1, 24'h20, 1, 1, 1, 24'h20, 8'h60);
    tv[13] = fr(24'h20, 0,  1, 0, 0, 24'h21, 0, 1, 1, 24'h20, 8'h60);
    tv[14] = fr(24'h1F, 0,  0, 1, 0, 24'h21, 0, 1, 1, 24'h20, 8'h60);
    tv[15] = mk(0, 0, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h21, 0, 0, 0, 0, 0);
    tv[16] = mk(0, 0, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h21, 0, 0, 0, 0, 0);
    tv[17] = mk(1, 24'h30, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[18] = fr(24'h2E, 0,  0, 1, 0, 24'h30, 0, 1, 0, 24'h2F, 8'h00);
    tv[19] = fr(24'h31, 0,  0, 0, 1, 24'h30, 1, 1, 1, 24'h30, 8'h60);
    tv[20] = mk(0, 0, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h30, 1, 0, 0, 0, 0);
    tv[21] = mk(0, 0, RTR, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[22] = mk(0, 0, R, 1, 1, 0, 1, 24'h30, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[23] = mk(0, 0, RTR, 1, 1, 0, 0, 24'h30, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[24] = mk(0, 0, R, 1, 0, 0, 0, 24'h30, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[25] = mk(0, 0, R, 1, 1, 1, 0, 24'h30, 1,  0, 0, 0, 24'h30, 0, 0, 0, 0, 0);
    tv[26] = fr(24'h30, 1,  1, 0, 0, 24'h31, 0, 0, 0, 0, 0);
    tv[27] = fr(24'h2F, 0,  0, 1, 0, 24'h31, 0, 1, 0, 24'h30, 8'h00);
    tv[28] = fr(24'h31, 0,  1, 0, 0, 24'h32, 0, 1, 0, 24'h30, 8'h00);
    tv[29] = fr(24'h2F, 0,  0, 1, 0, 24'h32, 0, 1, 0, 24'h31, 8'h00);
    tv[30] = mk(1, 24'h40, R, 1, 1, 0, 0, 24'h40, 0,  0, 0, 0, 24'h40, 0, 0, 0, 0, 0);
    tv[31] = fr(24'h40, 0,  1, 0, 0, 24'h41, 0, 0, 0, 0, 0);
    tv[32] = fr(24'h41, 0,  1, 0, 0, 24'h42, 0, 0, 0, 0, 0);
    tv[33] = fr(24'h42, 0,  1, 0, 0, 24'h43, 0, 0, 0, 0, 0);
    tv[34] = fr(24'h43, 0,  1, 0, 0, 24'h44, 0, 1, 0, 24'h43, 8'h00);
    tv[35] = fr(24'h3F, 1,  0, 1, 0, 24'h44, 0, 1, 0, 24'h43, 8'h00);
    tv[36] = mk(0, 0, R, 0, 0, 0, 0, 0, 1,  0, 0, 0, 24'h44, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(mk(0, 0, R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset ack_valid", 32'(ack_if.valid), 0);
    chk("reset epsn", 32'(epsn), 0);
    chk("reset pulses", {29'd0, data_accept, dup_drop, seq_err}, 0);
    chk("reset nak_outstanding", 32'(nak_outstanding), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d data_accept", i), 32'(data_accept), 32'(tv[i].da));
      chk($sformatf("v%0d dup_drop", i), 32'(dup_drop), 32'(tv[i].dd));
      chk($sformatf("v%0d seq_err", i), 32'(seq_err), 32'(tv[i].se));
      chk($sformatf("v%0d epsn", i), 32'(epsn), 32'(tv[i].ep));
      chk($sformatf("v%0d nak_outstanding", i), 32'(nak_outstanding), 32'(tv[i].no));
      chk($sformatf("v%0d ack_valid", i), 32'(ack_if.valid), 32'(tv[i].av));
      if (tv[i].av) begin
        chk($sformatf("v%0d ack_is_nak", i), 32'(ack_if.is_nak), 32'(tv[i].an));
        chk($sformatf("v%0d ack_psn", i), 32'(ack_if.psn), 32'(tv[i].ap));
        chk($sformatf("v%0d ack_syndrome", i), 32'(ack_if.syndrome), 32'(tv[i].as));
      end
    end
    @(negedge clk);
    drive(mk(1, 24'h50, R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(fr(24'h52, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("midrst pre nak_outstanding", 32'(nak_outstanding), 1);
    chk("midrst pre ack_valid", 32'(ack_if.valid), 1);
    drive(mk(0, 0, R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst ack_valid", 32'(ack_if.valid), 0);
    chk("midrst nak_outstanding", 32'(nak_outstanding), 0);
    chk("midrst epsn", 32'(epsn), 0);
    chk("midrst seq_err", 32'(seq_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(fr(24'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("post-reset data_accept", 32'(data_accept), 1);
    chk("post-reset epsn", 32'(epsn), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rdma_rc_psn_checker.md
Name: rdma_rc_psn_checker

Overview:
- Receive-side PSN sequencing stage, directly downstream of the RC PDU parser.
- Consumes registered parse results (opcode/PSN/frame-type/error flags, qualified by parse_done) and tracks the expected PSN (ePSN) per QP.
- Classifies each data frame as in-order, duplicate or out-of-sequence, then generates coalesced ACKs and PSN-sequence NAKs toward the TX responder over a valid/ready interface.

Parameters:
- PSN_WIDTH, 24, PSN width; all PSN arithmetic is modulo 2^PSN_WIDTH.
- OPCODE_WIDTH, 8, opcode width.
- ACK_COALESCE, 4, number of in-order data frames per generated ACK (1..255).
- SYN_ACK, 8'h00, ACK syndrome value.
- SYN_NAK_SEQ, 8'h60, PSN-sequence-error NAK syndrome value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- parse_done  in  1  parser result valid, one cycle per PDU
- pdu_opcode  in  OPCODE_WIDTH  parsed opcode
- pdu_psn  in  PSN_WIDTH  parsed PSN
- is_data_frame  in  1  data-frame flag
- opcode_err  in  1  parser opcode error
- qpn_mismatch_err  in  1  parser QPN error
- qp_state  in  3  QP state (RTS=3'b011)
- epsn_load  in  1  load ePSN from init_epsn (QP RTR transition)
- init_epsn  in  PSN_WIDTH  initial ePSN
- ack_ready  in  1  TX responder accepts ACK/NAK
- ack_valid  out  1  ACK/NAK pending
- ack_is_nak  out  1  1 = NAK
- ack_psn  out  PSN_WIDTH  PSN carried in ACK/NAK
- ack_syndrome  out  8  syndrome
- data_accept  out  1  pulse: frame in order, payload may be delivered
- dup_drop  out  1  pulse: duplicate frame dropped
- seq_err  out  1  pulse: out-of-sequence frame dropped
- epsn  out  PSN_WIDTH  current expected PSN
- nak_outstanding  out  1  in NAK_WAIT state

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. All outputs are 0 on reset; state is NORMAL and the coalesce counter is 0.
- Frame qualification: a frame is considered only when parse_done & is_data_frame & ~opcode_err & ~qpn_mismatch_err & (qp_state==RTS). All other parse_done cycles are ignored and cause no state change.
- Classification: d = (pdu_psn - epsn) mod 2^PSN_WIDTH.
  - d==0: in-order.
  - 1 <= d < 2^(PSN_WIDTH-1): out-of-sequence (future).
  - d >= 2^(PSN_WIDTH-1): duplicate.
- Timing: data_accept, dup_drop and seq_err are registered single-cycle pulses one cycle after the qualifying parse_done. ePSN update, counter update and ACK-register load land in the same edge.
- In-order frame (either state):
  - epsn <= epsn+1, wrapping 0xFFFFFF -> 0.
  - data_accept pulses; cnt <= cnt+1.
  - If cnt+1 == ACK_COALESCE: generate ACK with psn = pdu_psn, syndrome SYN_ACK, and reset cnt to 0.
  - In NAK_WAIT, the state returns to NORMAL.
- Out-of-sequence frame:
  - In NORMAL: generate NAK with psn = epsn, syndrome SYN_NAK_SEQ; go to NAK_WAIT.
  - In NAK_WAIT: drop silently with no new NAK.
  - seq_err pulses in both states; ePSN is unchanged.
- Duplicate frame: dup_drop pulses; generate ACK with psn = epsn-1 (mod) to re-acknowledge; cnt unchanged.
- ACK output register (depth 1):
  - ack_valid stays held until ack_valid & ack_ready; the fields are stable while ack_valid is high.
  - New ACK while an ACK is pending: overwrite psn (newest wins); ack_valid stays 1.
  - New NAK while an ACK is pending: NAK replaces it.
  - New ACK while a NAK is pending: discarded; the NAK is never overwritten.
  - Accept and load in the same cycle: the new entry loads and ack_valid stays 1.
- epsn_load: has priority over any same-cycle frame. It sets epsn = init_epsn, cnt = 0, state = NORMAL, and clears ack_valid. The same-cycle frame is ignored.
- Exit from RTS: leaving RTS (qp_state != RTS) while in NAK_WAIT returns the state to NORMAL. A pending ACK/NAK remains until accepted.
- Reset mid-operation clears everything immediately, including a pending ack_valid.

Optional Feature:
- Macro: RDMA_PSN_STATS_EN.
- Defined: adds outputs stat_dup_cnt, stat_seq_cnt, stat_ack_cnt (32-bit each, saturating at 0xFFFFFFFF), incremented on dup_drop, seq_err and ACK/NAK acceptance (ack_valid & ack_ready). The counters clear on reset and on epsn_load.
- Not defined: no counters and no such ports.

Test Plan:
- epsn_load init_epsn=0x000010; RTS; 4 frames PSN 0x10..0x13, ack_ready=1 -> 4 data_accept pulses; one ACK psn=0x000013 syndrome 0x00; epsn=0x000014.
- epsn=0xFFFFFE; in-order 0xFFFFFE, 0xFFFFFF, 0x000000 -> epsn=0x000001; no seq_err across the wrap.
- epsn=0x20; frame PSN 0x22 -> NAK psn=0x000020 syn 0x60, nak_outstanding=1; frame 0x23 -> seq_err, no second NAK; frame 0x20 -> data_accept, nak_outstanding=0.
- epsn=0x30; frame PSN 0x2E -> dup_drop, ACK psn=0x00002F; epsn stays 0x30.
- ack_ready=0; NAK pending, then duplicate generates ACK -> NAK fields retained; raise ack_ready -> exactly one NAK transfer.
- Frame with qpn_mismatch_err=1 or qp_state=RTR -> no pulses, epsn unchanged; epsn_load in the same cycle as a frame -> load wins, ack_valid cleared.
